// File: rtl/one_hot_pkg.sv
// Shared types and helpers for the binary/one-hot codec pipeline stage.
// Mode encoding and a lowest-set-bit index function.
package one_hot_pkg;

    typedef enum logic {
        MODE_ENCODE = 1'b0,
        MODE_DECODE = 1'b1
    } codec_mode_e;

    localparam int LSB_MAX_W = 256;

    // Scans high to low so the last hit is the lowest set bit; zero input yields 0.
    function automatic int lowest_set_index(input logic [LSB_MAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/one_hot_check.sv
// Combinational legality check of a one-hot vector.
// Reports zero/multi-bit conditions and isolates the lowest set bit.
module one_hot_check
    import one_hot_pkg::*;
#(
    parameter int IN_WIDTH      = 2,
    parameter int ONE_HOT_WIDTH = 1 << IN_WIDTH
) (
    input  logic [ONE_HOT_WIDTH-1:0] onehot_in,
    output logic                     is_zero,
    output logic                     is_multi,
    output logic [IN_WIDTH-1:0]      lsb_index,
    output logic [ONE_HOT_WIDTH-1:0] lsb_isolated
);

    logic [ONE_HOT_WIDTH-1:0] upper_bits;

    assign is_zero      = ~|onehot_in;
    assign lsb_isolated = onehot_in & (~onehot_in + ONE_HOT_WIDTH'(1));
    assign upper_bits   = onehot_in & ~lsb_isolated;
    assign is_multi     = |upper_bits;
    assign lsb_index    =
        IN_WIDTH'(lowest_set_index(LSB_MAX_W'(onehot_in)));

endmodule

// File: rtl/one_hot_codec_pipe.sv
// Registered binary/one-hot converter with valid/ready handshake
// and a saturating count of illegal inputs.
module one_hot_codec_pipe
    import one_hot_pkg::*;
#(
    parameter int IN_WIDTH      = 2,
    parameter int ONE_HOT_WIDTH = 1 << IN_WIDTH,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      bin_in,
    input  logic [ONE_HOT_WIDTH-1:0] onehot_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ONE_HOT_WIDTH-1:0] onehot_out,
    output logic [IN_WIDTH-1:0]      bin_out,
    output logic                     err_out,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic                     is_zero;
    logic                     is_multi;
    logic [IN_WIDTH-1:0]      lsb_idx;
    logic [ONE_HOT_WIDTH-1:0] lsb_iso;
    logic                     accept;
    logic                     in_range;
    logic [ONE_HOT_WIDTH-1:0] nxt_onehot;
    logic [IN_WIDTH-1:0]      nxt_bin;
    logic                     nxt_err;

    one_hot_check #(
        .IN_WIDTH      (IN_WIDTH),
        .ONE_HOT_WIDTH (ONE_HOT_WIDTH)
    ) u_check (
        .onehot_in    (onehot_in),
        .is_zero      (is_zero),
        .is_multi     (is_multi),
        .lsb_index    (lsb_idx),
        .lsb_isolated (lsb_iso)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_range = 32'(bin_in) < 32'(ONE_HOT_WIDTH);

    always_comb begin
        nxt_onehot = '0;
        nxt_bin    = '0;
        nxt_err    = 1'b0;
        if (codec_mode_e'(mode) == MODE_DECODE) begin
            nxt_onehot = lsb_iso;
            nxt_bin    = lsb_idx;
            nxt_err    = is_zero || is_multi;
        end else begin
            nxt_bin = bin_in;
            if (in_range) begin
                nxt_onehot = ONE_HOT_WIDTH'(1) << bin_in;
            end else begin
                nxt_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            onehot_out <= '0;
            bin_out    <= '0;
            err_out    <= 1'b0;
            err_count  <= '0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                onehot_out <= nxt_onehot;
                bin_out    <= nxt_bin;
                err_out    <= nxt_err;
                if (nxt_err && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_one_hot_codec_pipe.sv
// Directed bench: default instance plus a narrow instance
// (3-wide one-hot, 2-bit error counter).
module tb_one_hot_codec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       rst, mode, in_valid, in_ready, out_valid, out_ready, err_out;
    logic [1:0] bin_in, bin_out;
    logic [3:0] onehot_in, onehot_out;
    logic [7:0] err_count;

    // ONE_HOT_WIDTH = 3, ERR_CNT_WIDTH = 2 instance
    logic       rst_b, mode_b, in_valid_b, in_ready_b, out_valid_b;
    logic       out_ready_b, err_out_b;
    logic [1:0] bin_in_b, bin_out_b, err_count_b;
    logic [2:0] onehot_in_b, onehot_out_b;

    one_hot_codec_pipe u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin_in     (bin_in),
        .onehot_in  (onehot_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .onehot_out (onehot_out),
        .bin_out    (bin_out),
        .err_out    (err_out),
        .err_count  (err_count)
    );

    one_hot_codec_pipe #(
        .IN_WIDTH      (2),
        .ONE_HOT_WIDTH (3),
        .ERR_CNT_WIDTH (2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .mode       (mode_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .bin_in     (bin_in_b),
        .onehot_in  (onehot_in_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .onehot_out (onehot_out_b),
        .bin_out    (bin_out_b),
        .err_out    (err_out_b),
        .err_count  (err_count_b)
    );

    typedef struct {
        logic       mode;
        logic [1:0] bin;
        logic [3:0] oh;
        logic [3:0] exp_oh;
        logic [1:0] exp_bin;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    logic [2:0] sat_oh[5];
    logic [1:0] sat_bin[5];
    logic [2:0] sat_exp_oh[5];
    logic [1:0] sat_cnt[5];

    initial begin
        vecs[0] = '{1'b0, 2'd0, 4'b0000, 4'b0001, 2'd0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 2'd1, 4'b0000, 4'b0010, 2'd1, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 2'd2, 4'b0000, 4'b0100, 2'd2, 1'b0, 8'd0};
        vecs[3] = '{1'b0, 2'd3, 4'b0000, 4'b1000, 2'd3, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 2'd3, 4'b0100, 4'b0100, 2'd2, 1'b0, 8'd0};
        vecs[5] = '{1'b1, 2'd3, 4'b0000, 4'b0000, 2'd0, 1'b1, 8'd1};
        vecs[6] = '{1'b1, 2'd0, 4'b1010, 4'b0010, 2'd1, 1'b1, 8'd2};
        vecs[7] = '{1'b1, 2'd0, 4'b1000, 4'b1000, 2'd3, 1'b0, 8'd2};

        sat_oh[0] = 3'b000; sat_exp_oh[0] = 3'b000; sat_bin[0] = 2'd0;
        sat_oh[1] = 3'b011; sat_exp_oh[1] = 3'b001; sat_bin[1] = 2'd0;
        sat_oh[2] = 3'b111; sat_exp_oh[2] = 3'b001; sat_bin[2] = 2'd0;
        sat_oh[3] = 3'b000; sat_exp_oh[3] = 3'b000; sat_bin[3] = 2'd0;
        sat_oh[4] = 3'b110; sat_exp_oh[4] = 3'b010; sat_bin[4] = 2'd1;
        sat_cnt[0] = 2'd1; sat_cnt[1] = 2'd2; sat_cnt[2] = 2'd3;
        sat_cnt[3] = 2'd3; sat_cnt[4] = 2'd3;

        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        bin_in = '0; onehot_in = '0;
        rst_b = 1'b1; mode_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        bin_in_b = '0; onehot_in_b = '0;
        tick(); tick();
        rst = 1'b0; rst_b = 1'b0;
        #1;

        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_onehot", 32'(onehot_out), 0);
        chk("rst_bin", 32'(bin_out), 0);
        chk("rst_err", 32'(err_out), 0);
        chk("rst_cnt", 32'(err_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // back-to-back table with full throughput
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode; bin_in = vecs[i].bin;
            onehot_in = vecs[i].oh; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_onehot", i), 32'(onehot_out), 32'(vecs[i].exp_oh));
            chk($sformatf("v%0d_bin", i), 32'(bin_out), 32'(vecs[i].exp_bin));
            chk($sformatf("v%0d_err", i), 32'(err_out), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_cnt", i), 32'(err_count), 32'(vecs[i].exp_cnt));
        end

        // consume with no accept: valid drops, data held
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_bin_hold", 32'(bin_out), 3);
        chk("drain_oh_hold", 32'(onehot_out), 32'(4'b1000));

        // backpressure
        mode = 1'b0; bin_in = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_onehot", 32'(onehot_out), 32'(4'b0010));
        bin_in = 2'd2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 0);
            tick();
            chk($sformatf("bp%0d_hold_oh", i), 32'(onehot_out), 32'(4'b0010));
            chk($sformatf("bp%0d_hold_valid", i), 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(in_ready), 1);
        tick();
        chk("nobubble_valid", 32'(out_valid), 1);
        chk("nobubble_onehot", 32'(onehot_out), 32'(4'b0100));
        chk("nobubble_bin", 32'(bin_out), 2);

        // park a result under backpressure, then reset with an accept pending
        bin_in = 2'd3; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_cnt", 32'(err_count), 2);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        mode = 1'b1; onehot_in = 4'b0000;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_onehot", 32'(onehot_out), 0);
        chk("mid_rst_bin", 32'(bin_out), 0);
        chk("mid_rst_err", 32'(err_out), 0);
        chk("mid_rst_cnt", 32'(err_count), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);

        // narrow instance: out-of-range encode
        mode_b = 1'b0; in_valid_b = 1'b1; out_ready_b = 1'b1;
        bin_in_b = 2'd2;
        tick();
        chk("b_enc2_oh", 32'(onehot_out_b), 32'(3'b100));
        chk("b_enc2_err", 32'(err_out_b), 0);
        bin_in_b = 2'd3;
        tick();
        chk("b_oor_oh", 32'(onehot_out_b), 0);
        chk("b_oor_bin", 32'(bin_out_b), 3);
        chk("b_oor_err", 32'(err_out_b), 1);
        chk("b_oor_cnt", 32'(err_count_b), 1);

        // saturation of the 2-bit counter
        in_valid_b = 1'b0; rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_rst_cnt", 32'(err_count_b), 0);
        mode_b = 1'b1; in_valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            onehot_in_b = sat_oh[i];
            tick();
            chk($sformatf("sat%0d_cnt", i), 32'(err_count_b), 32'(sat_cnt[i]));
            chk($sformatf("sat%0d_oh", i), 32'(onehot_out_b), 32'(sat_exp_oh[i]));
            chk($sformatf("sat%0d_bin", i), 32'(bin_out_b), 32'(sat_bin[i]));
            chk($sformatf("sat%0d_err", i), 32'(err_out_b), 1);
        end
        in_valid_b = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
